pulse_transmitter_burst_generator: RTL and testbench
====================================================

# pulse_transmitter_burst_generator

Programmable burst engine sitting directly downstream of the pulse transmitter's rising-edge detector. Its single-cycle `start_pulse` input is driven by the detector's output. On each accepted start it emits a burst of `pulse_count` pulses, each with a programmable active width and gap, on `pulse_out`. It reports progress and completion to the peripheral register interface.

## Interface
Parameters:
- `TIME_WIDTH`, 16: width of the phase-duration inputs and the internal phase counter.
- `COUNT_WIDTH`, 8: width of the pulse-count input and the `pulses_sent` counter.

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start_pulse` in 1: one-cycle trigger from the edge detector.
- `stop` in 1: level abort request.
- `high_cycles` in `TIME_WIDTH`: active-phase length in clocks; 0 is treated as 1.
- `low_cycles` in `TIME_WIDTH`: gap-phase length in clocks; 0 is treated as 1.
- `pulse_count` in `COUNT_WIDTH`: number of pulses per burst.
- `idle_level` in 1: output level when not in the active phase.
- `pulse_out` out 1: registered transmitter output.
- `busy` out 1: high while in ACTIVE or GAP.
- `done` out 1: one-cycle burst-complete strobe.
- `pulses_sent` out `COUNT_WIDTH`: pulses completed in the current or last burst.

## Operation
- FSM has three states: IDLE, ACTIVE and GAP. Every output is registered.
- Reset (asynchronous, any state) sets: state IDLE, `pulse_out`=0, `busy`=0, `done`=0, `pulses_sent`=0, phase counter 0, all latched configuration 0.
- In IDLE, `pulse_out` follows `idle_level` with one cycle of delay.
- Start handling in IDLE:
  - `start_pulse`=1, `stop`=0 and `pulse_count`≠0: latch `high_cycles`, `low_cycles`, `pulse_count` and `idle_level`; clear `pulses_sent`; go to ACTIVE.
  - `start_pulse` with `pulse_count`=0: stay in IDLE, clear `pulses_sent`, strobe `done` next cycle.
- ACTIVE: `pulse_out` = ~latched idle level for max(high,1) cycles. On the last cycle, `pulses_sent` is incremented and the FSM goes to GAP.
- GAP: `pulse_out` = latched idle level for max(low,1) cycles. The final pulse also gets its full GAP.
- At the end of GAP:
  - If `pulses_sent` equals the latched count, go to IDLE and strobe `done`.
  - Otherwise go to ACTIVE.
- Input changes while busy are ignored, because configuration is latched at start.
- `start_pulse` while busy is ignored and is not queued.
- `stop`=1 in ACTIVE or GAP: next cycle is IDLE with `pulse_out` = latched idle level. `done` is not strobed and `pulses_sent` holds its value.
- `stop` and `start_pulse` in the same IDLE cycle: `stop` wins and nothing starts.
- Counter arithmetic is unsigned.
  - `pulses_sent` never exceeds the latched count.
  - The phase counter counts down from length−1 to 0 and never wraps.

## Timing
- Latency from start to output: `start_pulse` sampled at the edge ending cycle 0 gives `busy`=1 and active `pulse_out` in cycle 1.
- Worked example, high=2, low=3, count=2, idle_level=0, start in cycle 0:
  - `pulse_out`=1 in cycles 1–2 and 6–7; 0 in cycles 3–5 and 8–10.
  - `pulses_sent` reads 1 from cycle 3 and 2 from cycle 8.
  - `busy`=1 in cycles 1–10.
  - Cycle 11: `busy`=0 and `done`=1.
- Total burst length is count×(max(high,1)+max(low,1)) cycles.
- A new start is accepted in the first IDLE cycle, which is the same cycle as `done`.
- Stop latency is one cycle. Reset takes effect immediately, without waiting for a clock edge.

## Configuration
- Macro: `PULSE_TRANSMITTER_CONTINUOUS_EN`.
- When defined:
  - An extra input `continuous` (1 bit) is added and latched at start.
  - If the latched value is 1, the end of the final GAP goes straight to ACTIVE with no IDLE cycle.
  - On that wrap, `pulses_sent` resets to 0 and `done` strobes one cycle while `busy` stays 1.
  - The repetition continues until `stop` or reset.
- When undefined: the port is absent and every burst is single-shot.

## Test plan
- Reset mid-burst (assert `rst` during ACTIVE) -> `pulse_out`=0, `busy`=0, `done`=0 and `pulses_sent`=0 immediately. The next start behaves normally.
- high=2, low=3, count=2, idle_level=0, start at cycle 0 -> waveform exactly as in the worked example under Timing, with `done` only in cycle 11.
- high=0, low=0, count=3, idle_level=1 -> `pulse_out` alternates 0,1 for 6 cycles, then `done`. `pulses_sent` ends at 3.
- count=0 start -> no pulse output, `busy` stays 0, `done`=1 one cycle later.
- Start pulses at cycle 0 and cycle 2 with high=4, low=4, count=1 -> exactly one pulse. A further start in the `done` cycle launches a second burst.
- `stop` asserted in cycle 3 of a high=5, count=4 burst -> IDLE in cycle 4, no `done`, `pulses_sent`=0. Simultaneous `stop` and `start_pulse` in IDLE -> no burst.
- With `PULSE_TRANSMITTER_CONTINUOUS_EN` and `continuous`=1, count=2 -> `done` strobes every 2×(high+low) cycles with `busy` held at 1. `stop` ends the repetition.

Source files
------------

// File: rtl/pulse_transmitter_burst_generator_if.sv
// pulse_transmitter_burst_generator_if
//   Groups the burst engine's trigger, configuration and status signals.
//   master: drives start/stop/configuration, observes status (register block side).
//   slave : the burst engine itself.
//   Signals: start_pulse, stop, high_cycles, low_cycles, pulse_count, idle_level,
//            continuous (only with PULSE_TRANSMITTER_CONTINUOUS_EN), pulse_out, busy,
//            done, pulses_sent.
interface pulse_transmitter_burst_generator_if #(
  parameter int unsigned TIME_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 8
);
  logic                   start_pulse;
  logic                   stop;
  logic [TIME_WIDTH-1:0]  high_cycles;
  logic [TIME_WIDTH-1:0]  low_cycles;
  logic [COUNT_WIDTH-1:0] pulse_count;
  logic                   idle_level;
`ifdef PULSE_TRANSMITTER_CONTINUOUS_EN
  logic                   continuous;
`endif
  logic                   pulse_out;
  logic                   busy;
  logic                   done;
  logic [COUNT_WIDTH-1:0] pulses_sent;

  modport master (
`ifdef PULSE_TRANSMITTER_CONTINUOUS_EN
    output continuous,
`endif
    output start_pulse, stop, high_cycles, low_cycles, pulse_count, idle_level,
    input  pulse_out, busy, done, pulses_sent
  );

  modport slave (
`ifdef PULSE_TRANSMITTER_CONTINUOUS_EN
    input  continuous,
`endif
    input  start_pulse, stop, high_cycles, low_cycles, pulse_count, idle_level,
    output pulse_out, busy, done, pulses_sent
  );
endinterface

// File: rtl/pulse_transmitter_burst_generator.sv
// pulse_transmitter_burst_generator
//   On an accepted start, emits pulse_count pulses of max(high,1) active clocks and
//   max(low,1) gap clocks on pulse_out. Configuration is latched at start.
//   Ports: clk, rst (async, active-high), bus (slave modport of
//   pulse_transmitter_burst_generator_if).
//   Optional feature macro PULSE_TRANSMITTER_CONTINUOUS_EN: adds bus.continuous; when
//   latched high the burst repeats back-to-back until stop or reset.
module pulse_transmitter_burst_generator #(
  parameter int unsigned TIME_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input logic                                  clk,
  input logic                                  rst,
  pulse_transmitter_burst_generator_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

  state_e                 state_q, state_d;
  logic [TIME_WIDTH-1:0]  phase_q, phase_d;
  logic [TIME_WIDTH-1:0]  high_q, high_d;
  logic [TIME_WIDTH-1:0]  low_q, low_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] sent_q, sent_d;
  logic                   idle_q, idle_d;
  logic                   pulse_q, pulse_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wrap;

`ifdef PULSE_TRANSMITTER_CONTINUOUS_EN
  logic cont_q, cont_d;
  assign wrap = cont_q;
`else
  assign wrap = 1'b0;
`endif

  // Phase counter load value: a zero length behaves as one clock.
  function automatic logic [TIME_WIDTH-1:0] last_idx(input logic [TIME_WIDTH-1:0] len);
    return (len == '0) ? '0 : len - TIME_WIDTH'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    high_d  = high_q;
    low_d   = low_q;
    count_d = count_q;
    sent_d  = sent_q;
    idle_d  = idle_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PULSE_TRANSMITTER_CONTINUOUS_EN
    cont_d  = cont_q;
`endif
    unique case (state_q)
      StIdle: begin
        pulse_d = bus.idle_level;
        busy_d  = 1'b0;
        // stop has priority over a simultaneous start
        if (bus.start_pulse && !bus.stop) begin
          sent_d = '0;
          if (bus.pulse_count != '0) begin
            high_d  = bus.high_cycles;
            low_d   = bus.low_cycles;
            count_d = bus.pulse_count;
            idle_d  = bus.idle_level;
`ifdef PULSE_TRANSMITTER_CONTINUOUS_EN
            cont_d  = bus.continuous;
`endif
            state_d = StActive;
            phase_d = last_idx(bus.high_cycles);
            pulse_d = ~bus.idle_level;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StActive: begin
        if (bus.stop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          pulse_d = idle_q;
        end else if (phase_q == '0) begin
          sent_d  = sent_q + COUNT_WIDTH'(1);
          state_d = StGap;
          phase_d = last_idx(low_q);
          pulse_d = idle_q;
        end else begin
          phase_d = phase_q - TIME_WIDTH'(1);
        end
      end
      StGap: begin
        if (bus.stop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          pulse_d = idle_q;
        end else if (phase_q == '0) begin
          if (sent_q == count_q && !wrap) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pulse_d = idle_q;
          end else begin
            // Continuous wrap restarts the count and flags completion while staying busy.
            if (sent_q == count_q) begin
              sent_d = '0;
              done_d = 1'b1;
            end
            state_d = StActive;
            phase_d = last_idx(high_q);
            pulse_d = ~idle_q;
          end
        end else begin
          phase_d = phase_q - TIME_WIDTH'(1);
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      high_q  <= '0;
      low_q   <= '0;
      count_q <= '0;
      sent_q  <= '0;
      idle_q  <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PULSE_TRANSMITTER_CONTINUOUS_EN
      cont_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      high_q  <= high_d;
      low_q   <= low_d;
      count_q <= count_d;
      sent_q  <= sent_d;
      idle_q  <= idle_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PULSE_TRANSMITTER_CONTINUOUS_EN
      cont_q  <= cont_d;
`endif
    end
  end

  assign bus.pulse_out   = pulse_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pulses_sent = sent_q;

endmodule

// File: tb/tb_pulse_transmitter_burst_generator.sv
// tb_pulse_transmitter_burst_generator
//   Directed vectors with hand-computed expectations for the burst generator.
module tb_pulse_transmitter_burst_generator;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   hi_cnt;

  pulse_transmitter_burst_generator_if #(.TIME_WIDTH(16), .COUNT_WIDTH(8)) bus ();

  pulse_transmitter_burst_generator #(.TIME_WIDTH(16), .COUNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("wait_done", bus.done, 1);
  endtask

  task automatic cfg(input int h, input int l, input int c, input logic idle);
    bus.high_cycles = 16'(h);
    bus.low_cycles  = 16'(l);
    bus.pulse_count = 8'(c);
    bus.idle_level  = idle;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.start_pulse = 1'b0;
    bus.stop        = 1'b0;
    cfg(0, 0, 0, 1'b0);
`ifdef PULSE_TRANSMITTER_CONTINUOUS_EN
    bus.continuous = 1'b0;
`endif
    #2 rst = 1'b1;
    #1;
    chk("rst_pulse", bus.pulse_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sent", bus.pulses_sent, 0);
    #10 rst = 1'b0;

    // Reset in the middle of a burst
    step();
    cfg(1, 1, 3, 1'b0);
    bus.start_pulse = 1'b1;
    step();
    bus.start_pulse = 1'b0;
    step();
    step();
    chk("mid_busy_pre", bus.busy, 1);
    chk("mid_sent_pre", bus.pulses_sent, 1);
    chk("mid_pulse_pre", bus.pulse_out, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pulse", bus.pulse_out, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_sent", bus.pulses_sent, 0);
    #1 rst = 1'b0;

    // Worked example: high=2 low=3 count=2 idle=0
    step();
    cfg(2, 3, 2, 1'b0);
    bus.start_pulse = 1'b1;
    step();
    bus.start_pulse = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("ex_pulse_c%0d", c), bus.pulse_out,
          ((c >= 1 && c <= 2) || (c >= 6 && c <= 7)) ? 1 : 0);
      chk($sformatf("ex_sent_c%0d", c), bus.pulses_sent, (c < 3) ? 0 : (c < 8) ? 1 : 2);
      chk($sformatf("ex_busy_c%0d", c), bus.busy, (c <= 10) ? 1 : 0);
      chk($sformatf("ex_done_c%0d", c), bus.done, (c == 11) ? 1 : 0);
      if (c < 11) step();
    end

    // Zero lengths act as one, idle_level=1
    cfg(0, 0, 3, 1'b1);
    bus.start_pulse = 1'b1;
    step();
    bus.start_pulse = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("z_pulse_c%0d", c), bus.pulse_out, (c % 2 == 0) ? 1 : 0);
      chk($sformatf("z_busy_c%0d", c), bus.busy, 1);
      step();
    end
    chk("z_done", bus.done, 1);
    chk("z_busy_end", bus.busy, 0);
    chk("z_sent", bus.pulses_sent, 3);
    chk("z_pulse_end", bus.pulse_out, 1);

    // count=0 start: no burst, done next cycle, pulses_sent cleared
    cfg(0, 0, 0, 1'b0);
    bus.start_pulse = 1'b1;
    step();
    bus.start_pulse = 1'b0;
    chk("c0_done", bus.done, 1);
    chk("c0_busy", bus.busy, 0);
    chk("c0_sent", bus.pulses_sent, 0);
    chk("c0_pulse", bus.pulse_out, 0);
    step();
    chk("c0_done_clr", bus.done, 0);
    chk("c0_busy2", bus.busy, 0);

    // Start while busy ignored; start in done cycle accepted
    cfg(4, 4, 1, 1'b0);
    bus.start_pulse = 1'b1;
    step();
    hi_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      bus.start_pulse = (c == 2);
      if (bus.pulse_out === 1'b1) hi_cnt++;
      step();
    end
    bus.start_pulse = 1'b0;
    chk("sb_hi_cycles", hi_cnt, 4);
    chk("sb_done", bus.done, 1);
    chk("sb_busy", bus.busy, 0);
    chk("sb_sent", bus.pulses_sent, 1);
    bus.start_pulse = 1'b1;
    step();
    bus.start_pulse = 1'b0;
    chk("sb2_busy", bus.busy, 1);
    chk("sb2_pulse", bus.pulse_out, 1);
    chk("sb2_sent", bus.pulses_sent, 0);
    wait_done(20);
    chk("sb2_sent_end", bus.pulses_sent, 1);

    // Stop mid-active, idle_level=1
    cfg(5, 1, 4, 1'b1);
    bus.start_pulse = 1'b1;
    step();
    bus.start_pulse = 1'b0;
    step();
    step();
    chk("st_pulse_c3", bus.pulse_out, 0);
    chk("st_busy_c3", bus.busy, 1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("st_busy_c4", bus.busy, 0);
    chk("st_done_c4", bus.done, 0);
    chk("st_sent_c4", bus.pulses_sent, 0);
    chk("st_pulse_c4", bus.pulse_out, 1);
    step();
    chk("st_done_c5", bus.done, 0);
    chk("st_busy_c5", bus.busy, 0);
    bus.stop        = 1'b1;
    bus.start_pulse = 1'b1;
    step();
    bus.stop        = 1'b0;
    bus.start_pulse = 1'b0;
    chk("ss_busy", bus.busy, 0);
    chk("ss_done", bus.done, 0);
    step();
    chk("ss_busy2", bus.busy, 0);
    chk("ss_pulse", bus.pulse_out, 1);

`ifdef PULSE_TRANSMITTER_CONTINUOUS_EN
    // Continuous repetition: period 2*(1+2)=6
    cfg(1, 2, 2, 1'b0);
    bus.continuous  = 1'b1;
    bus.start_pulse = 1'b1;
    step();
    bus.start_pulse = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      chk($sformatf("ct_busy_c%0d", c), bus.busy, 1);
      chk($sformatf("ct_done_c%0d", c), bus.done, (c == 7 || c == 13) ? 1 : 0);
      if (c == 7) begin
        chk("ct_sent_wrap", bus.pulses_sent, 0);
        chk("ct_pulse_wrap", bus.pulse_out, 1);
      end
      if (c < 13) step();
    end
    bus.stop = 1'b1;
    step();
    bus.stop       = 1'b0;
    bus.continuous = 1'b0;
    chk("ct_stop_busy", bus.busy, 0);
    chk("ct_stop_done", bus.done, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
